axi_hp_wr_arbiter: RTL and testbench
====================================

// Module: axi_hp_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one PS AXI HP write port (PL->DDR) among NUM_REQ PL masters.
//  Sits between PL write masters (DMA, capture engines) and the HP slave port of the PS block.
//  One burst in flight: grants one requester for AW, W and B, then re-arbitrates. Tags AWID with the requester index.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..8
//  ADDR_W   32  address width
//  DATA_W   64  data width (HP port width); STRB_W = DATA_W/8
//  LEN_W    4   AWLEN width (AXI3 HP = 4)
//  ID_W     3   m_awid width, >= clog2(NUM_REQ)
// PORTS
//  aclk            in   1                  clock
//  aresetn         in   1                  sync reset, active-low
//  s_awaddr        in   NUM_REQ*ADDR_W     per-requester burst address, packed, req i at [i*ADDR_W +: ADDR_W]
//  s_awlen         in   NUM_REQ*LEN_W      per-requester burst length-1
//  s_awvalid       in   NUM_REQ            per-requester AW valid
//  s_awready       out  NUM_REQ            per-requester AW ready
//  s_wdata         in   NUM_REQ*DATA_W     per-requester write data
//  s_wstrb         in   NUM_REQ*STRB_W     per-requester byte strobes
//  s_wlast         in   NUM_REQ            requester's last-beat marker (checked only)
//  s_wvalid        in   NUM_REQ            per-requester W valid
//  s_wready        out  NUM_REQ            per-requester W ready
//  s_bresp         out  2                  B response, shared, qualified by s_bvalid
//  s_bvalid        out  NUM_REQ            per-requester B valid
//  s_bready        in   NUM_REQ            per-requester B ready
//  m_awaddr/len/id out  ADDR_W/LEN_W/ID_W  HP AW channel
//  m_awvalid       out  1                  HP AW valid
//  m_awready       in   1                  HP AW ready
//  m_wdata/wstrb   out  DATA_W/STRB_W      HP W channel
//  m_wlast         out  1                  internally generated last beat
//  m_wvalid        out  1                  HP W valid
//  m_wready        in   1                  HP W ready
//  m_bresp         in   2                  HP B response
//  m_bvalid        in   1                  HP B valid
//  m_bready        out  1                  HP B ready
//  err_wlast       out  1                  sticky: s_wlast disagreed with beat count
//  stat_grant_cnt  out  NUM_REQ*32         grant counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (aresetn=0 at posedge): state=IDLE, rr_ptr=NUM_REQ-1, gnt=0, beat_cnt=0. All valids, readies, err_wlast and counters = 0.
//  Reset mid-burst: same; the burst is abandoned (PS is reset together with PL).
//  FSM IDLE->AW->W->B->IDLE.
//  IDLE: winner = first i with s_awvalid[i], scanning rr_ptr+1, rr_ptr+2, ... mod NUM_REQ.
//   - s_awready[winner]=1 combinationally in the same cycle.
//   - Capture awaddr/awlen into m_aw regs; m_awid=winner, zero-extended.
//   - gnt=winner, beat_cnt=0, ->AW.
//  AW: m_awvalid=1, stable until m_awready; on handshake ->W. AW latency: m_awvalid rises 1 cycle after request accept.
//  W: m_wdata/m_wstrb/m_wvalid = s_w*[gnt]; s_wready[gnt]=m_wready; other s_wready=0.
//   - m_wlast = (beat_cnt==awlen). beat_cnt++ per W handshake.
//   - On the m_wlast handshake ->B.
//   - Any W handshake where s_wlast[gnt] != m_wlast sets err_wlast; the burst still completes with awlen+1 beats.
//  B: m_bready=s_bready[gnt]; s_bvalid[gnt]=m_bvalid; s_bresp=m_bresp passthrough.
//   - On handshake: rr_ptr=gnt, ->IDLE.
//   - SLVERR/DECERR are forwarded, not interpreted.
//  Non-granted requesters: s_awready=s_wready=s_bvalid=0; W may be presented early and is stalled.
//  Simultaneous requests: strict rotation; a continuously requesting master waits at most NUM_REQ-1 bursts.
//  awlen=0: single beat, m_wlast=1 on first beat. awlen=2^LEN_W-1: max beat_cnt, no wrap.
//  Min per-burst overhead: 1 IDLE + 1 AW + (awlen+1) W + 1 B cycles.
// CONFIGURATION
//  HP_ARB_STATS_EN defined:
//   - stat_grant_cnt[i*32 +: 32] increments on each IDLE grant to requester i.
//   - Counters wrap at 2^32 and clear on reset.
//  HP_ARB_STATS_EN undefined: no counters synthesised; stat_grant_cnt tied to 0.
// TESTING
//  T1 req0 only, awaddr=0x1000_0000, awlen=3 -> one AW, m_awid=0, 4 W beats, m_wlast on beat 4, s_bvalid[0] pulse; err_wlast=0.
//  T2 all 4 requesters held valid, 8 bursts -> grant order 0,1,2,3,0,1,2,3; stat_grant_cnt = 2 each (HP_ARB_STATS_EN defined).
//  T3 m_wready and m_awready random 50% backpressure, awlen=15 -> data beats in order; m_aw* stable while m_awvalid=1 and not ready.
//  T4 req2 awlen=1 with s_wlast=1 on beat 1 -> err_wlast=1 sticky; 2 beats sent; next burst proceeds normally.
//  T5 m_bresp=2'b10 -> s_bresp=2'b10 at s_bvalid[gnt]; s_bready=0 for 5 cycles -> FSM holds in B, no new AW issued.
//  T6 aresetn=0 during W beat 2 of 4 -> next cycle all m_* valids=0, s_*ready=0, err_wlast=0; after release, req1 is granted first.

Source files
------------

// File: rtl/axi_hp_wr_arbiter.sv
// Round-robin arbiter sharing one AXI HP write port among NUM_REQ masters, one burst in flight.
// Define HP_ARB_STATS_EN to build the per-requester grant counters on stat_grant_cnt.
module axi_hp_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 4,
  parameter int ID_W    = 3,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ*ADDR_W-1:0]  s_awaddr,
  input  logic [NUM_REQ*LEN_W-1:0]   s_awlen,
  input  logic [NUM_REQ-1:0]         s_awvalid,
  output logic [NUM_REQ-1:0]         s_awready,
  input  logic [NUM_REQ*DATA_W-1:0]  s_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]         s_wlast,
  input  logic [NUM_REQ-1:0]         s_wvalid,
  output logic [NUM_REQ-1:0]         s_wready,
  output logic [1:0]                 s_bresp,
  output logic [NUM_REQ-1:0]         s_bvalid,
  input  logic [NUM_REQ-1:0]         s_bready,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic [LEN_W-1:0]           m_awlen,
  output logic [ID_W-1:0]            m_awid,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [STRB_W-1:0]          m_wstrb,
  output logic                       m_wlast,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic                       err_wlast,
  output logic [NUM_REQ*32-1:0]      stat_grant_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d, gnt_q, gnt_d, win;
  logic               win_vld;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [LEN_W-1:0]   awlen_q, awlen_d, beat_q, beat_d;
  logic               err_q, err_d;

  logic [ADDR_W-1:0]  awaddr_a [NUM_REQ];
  logic [LEN_W-1:0]   awlen_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a  [NUM_REQ];
  logic [STRB_W-1:0]  wstrb_a  [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      awaddr_a[i] = s_awaddr[i*ADDR_W +: ADDR_W];
      awlen_a[i]  = s_awlen[i*LEN_W +: LEN_W];
      wdata_a[i]  = s_wdata[i*DATA_W +: DATA_W];
      wstrb_a[i]  = s_wstrb[i*STRB_W +: STRB_W];
    end
  end

  // Rotating priority: scan starts just after the last requester served.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] widx;
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(rr_q) + k) % NUM_REQ;
      widx = PTR_W'(idx);
      if (!win_vld && s_awvalid[widx]) begin
        win_vld = 1'b1;
        win     = widx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    beat_d    = beat_q;
    err_d     = err_q;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = m_bresp;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    m_wdata   = wdata_a[gnt_q];
    m_wstrb   = wstrb_a[gnt_q];
    case (state_q)
      S_IDLE: begin
        if (win_vld && aresetn) begin
          s_awready[win] = 1'b1;
          awaddr_d       = awaddr_a[win];
          awlen_d        = awlen_a[win];
          gnt_d          = win;
          beat_d         = '0;
          state_d        = S_AW;
        end
      end
      S_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_d = S_W;
      end
      S_W: begin
        m_wvalid         = s_wvalid[gnt_q];
        m_wlast          = (beat_q == awlen_q);
        s_wready[gnt_q]  = m_wready;
        if (m_wvalid && m_wready) begin
          // Beat count, not the requester's s_wlast, decides where the burst ends.
          if (s_wlast[gnt_q] != m_wlast) err_d = 1'b1;
          if (m_wlast) state_d = S_B;
          else         beat_d  = beat_q + 1'b1;
        end
      end
      S_B: begin
        m_bready         = s_bready[gnt_q];
        s_bvalid[gnt_q]  = m_bvalid;
        if (m_bvalid && m_bready) begin
          rr_d    = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      rr_q     <= PTR_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;
  assign m_awid    = ID_W'(gnt_q);
  assign err_wlast = err_q;

`ifdef HP_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_REQ];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (state_q == S_IDLE && win_vld) begin
      cnt_q[win] <= cnt_q[win] + 32'd1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) stat_grant_cnt[i*32 +: 32] = cnt_q[i];
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_hp_wr_arbiter.sv
// Scoreboard bench for axi_hp_wr_arbiter: requester and HP-slave models with expected AW/W/B queues.
module tb_axi_hp_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 4;
  localparam int IW = 3;
  localparam int SW = DW / 8;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N*AW-1:0] s_awaddr;
  logic [N*LW-1:0] s_awlen;
  logic [N-1:0]    s_awvalid, s_awready;
  logic [N*DW-1:0] s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N-1:0]    s_wlast, s_wvalid, s_wready;
  logic [1:0]      s_bresp;
  logic [N-1:0]    s_bvalid, s_bready;
  logic [AW-1:0]   m_awaddr;
  logic [LW-1:0]   m_awlen;
  logic [IW-1:0]   m_awid;
  logic            m_awvalid, m_awready;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_wlast, m_wvalid, m_wready;
  logic [1:0]      m_bresp;
  logic            m_bvalid, m_bready;
  logic            err_wlast;
  logic [N*32-1:0] stat_grant_cnt;

  axi_hp_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .err_wlast(err_wlast), .stat_grant_cnt(stat_grant_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; logic [IW-1:0] id; } aw_t;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } w_t;
  typedef struct { int idx; logic [1:0] resp; } b_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  b_t  b_q[$];
  int  glog[$];

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Configuration written by the main sequence
  int            posted[N];
  int            bad_seq[N];
  logic [LW-1:0] len_cfg[N];
  logic [AW-1:0] base_cfg[N];
  logic          bready_cfg[N];
  logic [1:0]    bresp_cfg;
  logic          aw_bp, w_bp;

  // Requester / slave model state, owned by the engine
  int            started[N];
  logic          act[N], awd[N], cbad[N];
  int            beat[N], cseq[N];
  logic [LW-1:0] clen[N];
  logic [AW-1:0] caddr[N];
  int            tb_rr, tb_gnt;
  logic          b_pend, err_exp;
  logic          g_hs[N], sw_hs[N];
  logic          mw_last_hs, mb_hs, err_set;

  function automatic logic [DW-1:0] mkdata(input int i, input int s, input int b);
    return {8'(i), 24'(s), 32'(b)};
  endfunction

  function automatic logic [SW-1:0] mkstrb(input int i, input int b);
    return SW'(b * 37 + i * 11 + 1);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_awvalid[i]           = act[i] && !awd[i];
      s_awaddr[i*AW +: AW]   = caddr[i];
      s_awlen[i*LW +: LW]    = clen[i];
      s_wvalid[i]            = act[i];
      s_wdata[i*DW +: DW]    = mkdata(i, cseq[i], beat[i]);
      s_wstrb[i*SW +: SW]    = mkstrb(i, beat[i]);
      s_wlast[i]             = (beat[i] == int'(clen[i])) ^ (cbad[i] && beat[i] == 0);
      s_bready[i]            = bready_cfg[i];
    end
    m_bvalid = b_pend;
    m_bresp  = bresp_cfg;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; awd[i] = 1'b0; cbad[i] = 1'b0; beat[i] = 0; cseq[i] = 0;
      clen[i] = '0; caddr[i] = '0; started[i] = posted[i];
    end
    aw_q.delete(); w_q.delete(); b_q.delete(); glog.delete();
    b_pend = 1'b0; err_exp = 1'b0; tb_rr = N - 1; tb_gnt = 0;
  endtask

  // Engine: observe at negedge, update requester/slave models just after posedge.
  initial begin
    for (int i = 0; i < N; i++) begin
      posted[i] = 0; bad_seq[i] = -1; len_cfg[i] = '0; base_cfg[i] = '0; bready_cfg[i] = 1'b1;
    end
    bresp_cfg = 2'b00; aw_bp = 1'b0; w_bp = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1;
    model_reset();
    drive();
    forever begin
      @(negedge aclk);
      for (int i = 0; i < N; i++) begin g_hs[i] = 1'b0; sw_hs[i] = 1'b0; end
      mw_last_hs = 1'b0; mb_hs = 1'b0; err_set = 1'b0;
      if (aresetn) begin
        for (int i = 0; i < N; i++) begin
          if (s_awvalid[i] && s_awready[i]) begin
            int expw;
            expw = -1;
            for (int k = 1; k <= N; k++) begin
              int j;
              j = (tb_rr + k) % N;
              if (expw < 0 && s_awvalid[j]) expw = j;
            end
            check("grant", 64'(i), 64'(expw));
            g_hs[i] = 1'b1;
            aw_q.push_back('{addr: caddr[i], len: clen[i], id: IW'(i)});
            for (int b = 0; b <= int'(clen[i]); b++)
              w_q.push_back('{data: mkdata(i, cseq[i], b), strb: mkstrb(i, b), last: (b == int'(clen[i]))});
            tb_gnt = i;
            glog.push_back(i);
          end
        end
        if (m_awvalid) begin
          if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
          else begin
            check("m_awaddr", m_awaddr, aw_q[0].addr);
            check("m_awlen", m_awlen, aw_q[0].len);
            check("m_awid", m_awid, aw_q[0].id);
            if (m_awready) void'(aw_q.pop_front());
          end
        end
        for (int i = 0; i < N; i++) begin
          sw_hs[i] = s_wvalid[i] && s_wready[i];
          if (sw_hs[i] && (s_wlast[i] != (beat[i] == int'(clen[i])))) err_set = 1'b1;
        end
        if (m_wvalid && m_wready) begin
          if (w_q.size() == 0) check("w_unexpected", 1, 0);
          else begin
            w_t e;
            e = w_q.pop_front();
            check("m_wdata", m_wdata, e.data);
            check("m_wstrb", m_wstrb, e.strb);
            check("m_wlast", m_wlast, e.last);
            if (e.last) begin
              b_q.push_back('{idx: tb_gnt, resp: bresp_cfg});
              mw_last_hs = 1'b1;
            end
          end
          check("w_src", sw_hs[tb_gnt], 1);
        end
        mb_hs = m_bvalid && m_bready;
        for (int i = 0; i < N; i++) begin
          if (s_bvalid[i]) begin
            if (b_q.size() == 0) check("b_unexpected", 1, 0);
            else begin
              check("b_idx", 64'(i), 64'(b_q[0].idx));
              check("s_bresp", s_bresp, b_q[0].resp);
              if (s_bready[i]) begin
                void'(b_q.pop_front());
                tb_rr = i;
              end
            end
          end
        end
        check("err_wlast", err_wlast, err_exp);
      end
      @(posedge aclk);
      #1;
      if (!aresetn) model_reset();
      else begin
        for (int i = 0; i < N; i++) begin
          if (g_hs[i]) awd[i] = 1'b1;
          if (sw_hs[i]) begin
            if (beat[i] == int'(clen[i])) act[i] = 1'b0;
            else beat[i]++;
          end
          if (!act[i] && started[i] < posted[i]) begin
            act[i]   = 1'b1;
            awd[i]   = 1'b0;
            beat[i]  = 0;
            clen[i]  = len_cfg[i];
            caddr[i] = base_cfg[i] + AW'(started[i]) * 32'h100;
            cbad[i]  = (bad_seq[i] == started[i]);
            cseq[i]  = started[i];
            started[i]++;
          end
        end
        if (mb_hs) b_pend = 1'b0;
        if (mw_last_hs) b_pend = 1'b1;
        if (err_set) err_exp = 1'b1;
      end
      m_awready = aw_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_wready  = w_bp  ? 1'($urandom_range(0, 1)) : 1'b1;
      drive();
    end
  end

  task automatic do_reset();
    @(negedge aclk); #2;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    #2;
    aresetn = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge aclk); #2;
      done = !b_pend && aw_q.size() == 0 && w_q.size() == 0 && b_q.size() == 0 && s_bvalid == '0;
      for (int i = 0; i < N; i++) if (act[i] || started[i] != posted[i]) done = 1'b0;
    end
    if (!done) check(tag, 0, 1);
  endtask

  logic [31:0] exp_stat;

  initial begin
    do_reset();
    @(negedge aclk); #2;
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_m_wvalid", m_wvalid, 0);
    check("rst_s_ready", {s_awready, s_wready, s_bvalid}, 0);
    check("rst_m_bready", m_bready, 0);
    check("rst_err", err_wlast, 0);
    check("rst_stat", stat_grant_cnt, 0);

    // T1: single requester, 4-beat burst
    len_cfg[0] = 4'd3; base_cfg[0] = 32'h1000_0000; posted[0]++;
    wait_done("t1_timeout", 200);
    check("t1_grants", 64'(glog.size()), 1);
    check("t1_err", err_wlast, 0);

    // T2: all requesters, two bursts each, strict rotation
    do_reset();
    for (int i = 0; i < N; i++) begin
      len_cfg[i] = 4'd1; base_cfg[i] = 32'h2000_0000 + 32'(i) * 32'h1_0000; posted[i] += 2;
    end
    wait_done("t2_timeout", 500);
    check("t2_grants", 64'(glog.size()), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) check("t2_order", 64'(glog[k]), 64'(k % N));
`ifdef HP_ARB_STATS_EN
    exp_stat = 32'd2;
`else
    exp_stat = 32'd0;
`endif
    for (int i = 0; i < N; i++) check("t2_stat", stat_grant_cnt[i*32 +: 32], exp_stat);

    // T3: random backpressure with max-length bursts
    aw_bp = 1'b1; w_bp = 1'b1;
    len_cfg[1] = 4'd15; base_cfg[1] = 32'h3000_0000; posted[1] += 2;
    len_cfg[3] = 4'd15; base_cfg[3] = 32'h3100_0000; posted[3] += 1;
    wait_done("t3_timeout", 2000);
    aw_bp = 1'b0; w_bp = 1'b0;

    // T4: wrong s_wlast on first beat of a 2-beat burst, then a clean burst
    len_cfg[2] = 4'd1; base_cfg[2] = 32'h4000_0000; bad_seq[2] = started[2]; posted[2]++;
    wait_done("t4a_timeout", 200);
    check("t4_err_set", err_wlast, 1);
    len_cfg[0] = 4'd2; base_cfg[0] = 32'h4100_0000; posted[0]++;
    wait_done("t4b_timeout", 200);
    check("t4_err_sticky", err_wlast, 1);

    // T5: SLVERR forwarded; requester holds off B for 5 cycles
    bresp_cfg = 2'b10; bready_cfg[3] = 1'b0;
    len_cfg[3] = 4'd0; base_cfg[3] = 32'h5000_0000; posted[3]++;
    len_cfg[0] = 4'd0; base_cfg[0] = 32'h5100_0000; posted[0]++;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge aclk); #2;
        seen = s_bvalid[3];
      end
      check("t5_bvalid_seen", seen, 1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk); #2;
      check("t5_hold_bvalid", s_bvalid, 4'b1000);
      check("t5_hold_bresp", s_bresp, 2'b10);
      check("t5_hold_noaw", {m_awvalid, s_awready}, 0);
    end
    bready_cfg[3] = 1'b1;
    wait_done("t5_timeout", 200);
    bresp_cfg = 2'b00;

    // T6: reset in the middle of a W burst
    len_cfg[0] = 4'd3; base_cfg[0] = 32'h6000_0000; posted[0]++;
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
        @(negedge aclk); #2;
        hit = act[0] && beat[0] == 1;
      end
      check("t6_mid_burst", hit, 1);
    end
    aresetn = 1'b0;
    @(negedge aclk); #2;
    check("t6_m_valids", {m_awvalid, m_wvalid, m_bready}, 0);
    check("t6_s_ready", {s_awready, s_wready, s_bvalid}, 0);
    check("t6_err", err_wlast, 0);
    check("t6_stat", stat_grant_cnt, 0);
    @(negedge aclk); #2;
    aresetn = 1'b1;
    for (int i = 1; i < N; i++) begin
      len_cfg[i] = 4'd0; base_cfg[i] = 32'h7000_0000 + 32'(i) * 32'h1000; posted[i]++;
    end
    wait_done("t6_timeout", 300);
    check("t6_first_grant", (glog.size() > 0) ? 64'(glog[0]) : 64'hFFFF, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
